// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: parity modes, TX state encoding, baud counter width
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } tx_state_t;

   // Width needed to count 0..div-1; never narrower than one bit.
   function automatic int baud_cnt_width(input int div);
      return (div < 2) ? 1 : $clog2(div);
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter with enable/clear, flags the last cycle of each bit
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   en        - count while high
//   clr       - synchronous clear to 0 (wins over en)
//   bit_end   - high in the final cycle (count == BAUD_DIV-1) of a bit period while enabled
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = 434
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic bit_end
);

   localparam int CW = baud_cnt_width(BAUD_DIV);
   localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

   assign bit_end = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter (5-9 data bits, none/odd/even parity, 1-2 stop bits)
// Ports:
//   CLK, RST     - system clock, asynchronous active-high reset
//   TX_Data      - word to send, sampled only on acceptance (TX_Valid && TX_Ready)
//   TX_Valid     - send request
//   TX_Ready     - high when a word can be accepted
//   TX_Busy      - high while a frame is on the line
//   TX_Done_Sig  - one-cycle pulse as the last stop bit completes
//   TX_Pin_Out   - serial line, idles high, driven straight from a flop
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int BAUD_DIV  = 434,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [DATA_BITS-1:0] TX_Data,
   input  logic                 TX_Valid,
   output logic                 TX_Ready,
   output logic                 TX_Busy,
   output logic                 TX_Done_Sig,
   output logic                 TX_Pin_Out
);

   tx_state_t state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [3:0]           bit_idx_q, bit_idx_d;
   logic                 stop_idx_q, stop_idx_d;
   logic                 par_q, par_d;
   logic                 pin_q, pin_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 bit_end;
   logic                 baud_clr;

   // Counter is held at 0 in IDLE and restarts on every state change.
   assign baud_clr = (state_q == S_IDLE) || (state_d != state_q);

   uart_baud_gen #(
      .BAUD_DIV(BAUD_DIV)
   ) u_baud (
      .clk     (CLK),
      .rst     (RST),
      .en      (state_q != S_IDLE),
      .clr     (baud_clr),
      .bit_end (bit_end)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= S_IDLE;
         shift_q    <= '0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         par_q      <= 1'b0;
         pin_q      <= 1'b1;
         ready_q    <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         par_q      <= par_d;
         pin_q      <= pin_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Next-state logic also computes the next line level, so the pin flop
   // changes on the same edge as the state it belongs to.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      par_d      = par_q;
      pin_d      = pin_q;
      ready_d    = ready_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            pin_d   = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            if (TX_Valid && ready_q) begin
               shift_d = TX_Data;
               par_d   = (PARITY == PARITY_ODD) ? ~^TX_Data : ^TX_Data;
               state_d = S_START;
               pin_d   = 1'b0;
               ready_d = 1'b0;
               busy_d  = 1'b1;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d   = S_DATA;
               bit_idx_d = '0;
               pin_d     = shift_q[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_idx_q == 4'(DATA_BITS - 1)) begin
                  if (PARITY != PARITY_NONE) begin
                     state_d = S_PARITY;
                     pin_d   = par_q;
                  end else begin
                     state_d    = S_STOP;
                     stop_idx_d = 1'b0;
                     pin_d      = 1'b1;
                  end
               end else begin
                  shift_d   = shift_q >> 1;
                  bit_idx_d = bit_idx_q + 4'd1;
                  pin_d     = shift_q[1];
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d    = S_STOP;
               stop_idx_d = 1'b0;
               pin_d      = 1'b1;
            end
         end
         S_STOP: begin
            pin_d = 1'b1;
            if (bit_end) begin
               if (stop_idx_q == 1'(STOP_BITS - 1)) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
                  ready_d = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  stop_idx_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            pin_d   = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign TX_Pin_Out  = pin_q;
   assign TX_Ready    = ready_q;
   assign TX_Busy     = busy_q;
   assign TX_Done_Sig = done_q;

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter. Serialises one data word per valid/ready handshake into a configurable frame: start bit, 5–9 data bits LSB first, optional odd/even parity, and 1 or 2 stop bits. The baud rate is a fixed divisor of CLK. It replaces the fixed 8N1 transmitter and sits between the host-side command logic and the board TX pin.

Parameters:
BAUD_DIV, 434, CLK cycles per bit (434 = 50 MHz / 115200); legal range 2..65535.
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
CLK  input  1  system clock.
RST  input  1  asynchronous, active-high reset.
TX_Data  input  DATA_BITS  word to send; sampled only on acceptance.
TX_Valid  input  1  request to send TX_Data.
TX_Ready  output  1  high when a word can be accepted.
TX_Busy  output  1  high while a frame is on the line.
TX_Done_Sig  output  1  one-cycle pulse when a frame's last stop bit completes.
TX_Pin_Out  output  1  serial line; idles high.

Behaviour:
- Reset (asynchronous): state IDLE, TX_Pin_Out=1, TX_Ready=1, TX_Busy=0, TX_Done_Sig=0, baud counter=0, shift register=0.
- Reset asserted mid-frame: the line returns high immediately and the frame is abandoned. No Done pulse is produced.
- Acceptance: TX_Valid && TX_Ready at a rising edge. On that edge:
  - TX_Data is latched into the shift register and its parity is computed.
  - State goes to START; TX_Ready drops and TX_Busy rises.
- TX_Valid while not ready is ignored; it is neither queued nor an error.
- State machine: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE. PARITY is skipped when PARITY=0.
- Bit timing:
  - Every state except IDLE holds its line value for exactly BAUD_DIV cycles.
  - The baud counter counts 0..BAUD_DIV-1, clears on every state change, and is held at 0 in IDLE.
- Line value per state:
  - START: 0.
  - DATA: shift_reg[0]; the register shifts right at each bit boundary; bit index counts 0..DATA_BITS-1.
  - PARITY: odd gives ~^data; even gives ^data (data = the latched word).
  - STOP: 1, held for STOP_BITS*BAUD_DIV cycles.
- Latency: TX_Pin_Out falls on the edge that accepts the word, i.e. first low in the cycle after acceptance.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * BAUD_DIV cycles.
- Completion: the edge ending the last stop-bit cycle sets IDLE, TX_Done_Sig=1 (one cycle only), TX_Ready=1 and TX_Busy=0 simultaneously.
- Back-to-back: a word presented with Valid held high is accepted in that first IDLE cycle. The next start bit therefore begins exactly one cycle after the previous stop bit ends; the line is high during that cycle.
- TX_Data changing after acceptance has no effect on the frame in flight.
- All outputs are registered; TX_Pin_Out comes straight from a flop, with no glitches.

Decomposition:
- Shared package uart_pkg holds:
  - PARITY_NONE/ODD/EVEN localparams (0/1/2);
  - state encodings S_IDLE, S_START, S_DATA, S_PARITY, S_STOP;
  - a function for baud-counter width, clog2(BAUD_DIV).
- Sub-module uart_baud_gen: counter with enable/clear, emits bit_end when count==BAUD_DIV-1. It is shared with the planned parametrised receiver.
- The FSM, shift register and parity logic stay in uart_tx_param.

Test Plan:
- Reset value and mid-frame reset (BAUD_DIV=4, 8N1, 0xA5):
  - After reset: Pin=1, Ready=1, Busy=0.
  - Accept 0xA5 -> Pin = 0, then 1,0,1,0,0,1,0,1, then 1; each level lasts 4 cycles. Done pulses at cycle 40 after acceptance; Ready=1 in the same cycle.
  - Assert RST at frame cycle 13 -> Pin=1 immediately, no Done pulse; a new word is accepted cleanly afterwards.
- Parity (DATA_BITS=7, PARITY=2 even, BAUD_DIV=4, 0x55, four ones) -> parity bit 0; frame is 40 cycles. With PARITY=1 the parity bit is 1.
- Two stop bits (STOP_BITS=2, 8N1 otherwise, BAUD_DIV=4, 0x00) -> 8 low data-bit periods, then line high for 8 cycles before Done.
- Back-to-back (Valid held high, words 0x01 then 0x80) -> exactly one high idle cycle between frames, two Done pulses, second frame bits correct.
- Busy protection:
  - Toggle TX_Data and pulse TX_Valid mid-frame -> transmitted bits unchanged, no extra frame.
  - Minimum divisor BAUD_DIV=2 -> 20-cycle frame.
